mac_row_accumulator: RTL

Multiply-accumulate stage directly downstream of the matrix-multiply address generator. Consumes one operand pair per accepted beat: an M1 element and an M2 element read at the generated addresses, tagged with the current M1 row index. It accumulates `TERMS` signed products into one dot-product result and presents that result on a valid/ready output, together with its row index. It also counts completed rows and pulses `mat_done` after `ROWS` results.

---
 rtl/mac_row_accumulator.sv | 82 ++++++++
 1 files changed

// File: rtl/mac_row_accumulator.sv
// mac_row_accumulator: accumulates TERMS signed products per row into a valid/ready result,
// flagging row-index changes within a dot product and pulsing mat_done every ROWS results.
module mac_row_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int TERMS  = 8,
    parameter int ROWS   = 8,
    localparam int TW = $clog2(TERMS),
    localparam int RW = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    input  logic [RW-1:0]     in_row_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  out_data_o,
    output logic [RW-1:0]     out_row_o,
    output logic              mat_done_o,
    output logic              row_err_o
);
    logic [TW-1:0]           term_q, term_d;
    logic [RW-1:0]           rows_done_q, rows_done_d, cur_row_q, cur_row_d, out_row_q, out_row_d;
    logic [ACC_W-1:0]        acc_q, acc_d, out_data_q, out_data_d, prod_ext, sum;
    logic                    out_valid_q, out_valid_d, mat_done_q, mat_done_d, row_err_q, row_err_d;
    logic signed [2*DATA_W-1:0] prod;
    logic                    accept, first, done;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign prod       = $signed(in_a_i) * $signed(in_b_i);
    assign prod_ext   = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign first      = term_q == '0;
    assign sum        = first ? prod_ext : acc_q + prod_ext;
    assign done       = accept && term_q == TW'(TERMS-1);

    always_comb begin
        // term and rows_done are power-of-two wide, so the increment wraps on its own
        term_d      = accept ? term_q + 1'b1 : term_q;
        acc_d       = accept ? sum : acc_q;
        cur_row_d   = accept && first ? in_row_i : cur_row_q;
        row_err_d   = row_err_q || (accept && !first && in_row_i != cur_row_q);
        rows_done_d = done ? rows_done_q + 1'b1 : rows_done_q;
        mat_done_d  = done && rows_done_q == RW'(ROWS-1);
        out_valid_d = done || (out_valid_q && !out_ready_i);
        out_data_d  = done ? sum : out_data_q;
        out_row_d   = done ? (first ? in_row_i : cur_row_q) : out_row_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            term_q      <= '0;
            acc_q       <= '0;
            cur_row_q   <= '0;
            row_err_q   <= 1'b0;
            rows_done_q <= '0;
            mat_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
        end else begin
            term_q      <= term_d;
            acc_q       <= acc_d;
            cur_row_q   <= cur_row_d;
            row_err_q   <= row_err_d;
            rows_done_q <= rows_done_d;
            mat_done_q  <= mat_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_row_o   = out_row_q;
    assign mat_done_o  = mat_done_q;
    assign row_err_o   = row_err_q;
endmodule
